// File: rtl/jk_updown_counter_pkg.sv
// Shared JK definitions for the JK-based counter and its cells.
//   HOLD/RST/SET/TGL : {J,K} encodings driven into a JK cell
//   jk_excite(q, n)  : excitation table lookup, returns {J,K} that moves a
//                      cell from present state q to desired next state n.
//                      Don't-cares resolve to 0, so TGL is never produced.
package jk_pkg;

  localparam logic [1:0] HOLD = 2'b00;
  localparam logic [1:0] RST  = 2'b01;
  localparam logic [1:0] SET  = 2'b10;
  localparam logic [1:0] TGL  = 2'b11;

  function automatic logic [1:0] jk_excite(input logic q, input logic n);
    logic [1:0] jk;
    if (q == n) begin
      jk = HOLD;
    end else if (n) begin
      jk = SET;
    end else begin
      jk = RST;
    end
    return jk;
  endfunction

endpackage

// File: rtl/jk_updown_counter_cell.sv
// Single JK flip-flop cell.
//   clk   : rising-edge clock
//   reset : asynchronous, active-high; clears q
//   j, k  : JK inputs (00 hold, 01 reset, 10 set, 11 toggle)
//   q     : cell state
module jk_cell
  import jk_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic j,
  input  logic k,
  output logic q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= 1'b0;
    end else begin
      case ({j, k})
        HOLD:    q <= q;
        RST:     q <= 1'b0;
        SET:     q <= 1'b1;
        default: q <= ~q;
      endcase
    end
  end

endmodule

// File: rtl/jk_updown_counter.sv
// Modulo-MODULUS up/down counter whose state lives entirely in JK cells.
// The next count is computed first, then translated into per-cell J/K
// drives through the JK excitation table.
//   clk      : rising-edge clock
//   reset    : asynchronous, active-high; clears all cells
//   en       : count enable
//   up       : 1 = count up, 0 = count down (used when en=1)
//   load     : synchronous load, priority over en
//   load_val : value to load, clamped to MODULUS-1
//   q        : current count (cell outputs)
//   tc       : terminal count, high in the cycle before wrap
//   j_vec    : J drives presented to the cells this cycle
//   k_vec    : K drives presented to the cells this cycle
module jk_updown_counter
  import jk_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic [WIDTH-1:0] j_vec,
  output logic [WIDTH-1:0] k_vec
);

  localparam logic [WIDTH-1:0] TOP = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
    $error("jk_updown_counter: MODULUS %0d out of range for WIDTH %0d", MODULUS, WIDTH);
  end

  logic [WIDTH-1:0] nxt;

  // While reset is held the desired next state is the present state, so the
  // debug J/K vectors and tc read as zero rather than showing a pending step.
  always_comb begin
    nxt   = q;
    j_vec = '0;
    k_vec = '0;
    if (!reset) begin
      if (load) begin
        nxt = (load_val > TOP) ? TOP : load_val;
      end else if (en) begin
        if (up) begin
          // >= also folds out-of-range states back to 0
          nxt = (q >= TOP) ? '0 : q + ONE;
        end else begin
          nxt = (q == '0) ? TOP : q - ONE;
        end
      end
    end
    for (int unsigned i = 0; i < WIDTH; i++) begin
      {j_vec[i], k_vec[i]} = jk_excite(q[i], nxt[i]);
    end
    tc = ~reset & en & ~load & (up ? (q == TOP) : (q == '0));
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_cell
    jk_cell u_cell (
      .clk   (clk),
      .reset (reset),
      .j     (j_vec[g]),
      .k     (k_vec[g]),
      .q     (q[g])
    );
  end

endmodule
